rc4_ksa_engine: RTL
===================

Name: rc4_ksa_engine

Overview:
- Parametrised RC4 key-scheduling engine; next generation of the fixed 24-bit-key S-box initialiser.
- Drives a single-port synchronous S-box RAM (2^ADDR_W words, ADDR_W bits each):
  - Phase 1: writes S[i]=i.
  - Phase 2: runs the KSA swap loop.
- Adds a start/busy/done handshake, a key latched at start, and a generic key length.
- Sits between the key source (switches/cracker) and the S-box RAM, ahead of the PRGA/decrypt stage.

Parameters:
- ADDR_W, 8, S-box address and data width; N = 2^ADDR_W entries.
- KEY_BYTES, 3, key length in bytes; 1..32.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request a run; sampled only when busy=0.
- secret_key  in  8*KEY_BYTES  key; byte 0 = most significant byte; latched on start acceptance.
- q  in  ADDR_W  RAM read data; valid one cycle after address is presented with wren=0.
- address  out  ADDR_W  RAM address.
- data  out  ADDR_W  RAM write data.
- wren  out  1  RAM write enable.
- busy  out  1  high from acceptance until DONE is entered.
- done  out  1  level; high in DONE until the next start is accepted.

Behaviour:
- Reset (reset=0, immediate, asynchronous):
  - address=0, data=0, wren=0, busy=0, done=0.
  - i=0, j=0, kidx=0, state=IDLE.
  - RAM contents after reset are unspecified; the next run reinitialises them.
- All outputs come from registers (Moore). "State X" means the cycle in which outputs reflect X.
- Start acceptance:
  - start=1 in IDLE or DONE: latch the key, clear i/j/kidx, set busy=1, done=0, then enter INIT next cycle.
  - start while busy is ignored.
  - secret_key changes after acceptance are ignored.
- INIT: address=i, data=i, wren=1, one write per cycle for N cycles. After i=N-1, set i=0 and go to RD_I.
- KSA loop, 6 cycles per i:
  - RD_I: address=i, wren=0.
  - WT_I: address=i. Capture si<=q. Compute j <= (j + q + key[kidx]) mod N.
  - RD_J: address=j, wren=0.
  - WT_J: capture sj<=q.
  - WR_I: address=i, data=sj, wren=1.
  - WR_J: address=j, data=si, wren=1.
  - After WR_J: if i=N-1 go to DONE, else i++, kidx++ (wrapping at KEY_BYTES-1 to 0), go to RD_I.
- Arithmetic:
  - j uses ADDR_W-bit modular addition.
  - For ADDR_W<8, only the low ADDR_W bits of the key byte are used.
  - kidx is a wrapping counter; no divider.
- i=j: both writes target the same address with the same value; the result is correct and needs no special case.
- DONE: busy=0, done=1, wren=0, address holds its last value.
- Latency: N + 6N cycles from acceptance to done=1. For N=256 this is 1792 cycles.
- Reset mid-run aborts at once. The next start reruns the full INIT and KSA.

Decomposition:
- Package rc4_pkg:
  - State enum: IDLE, INIT, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, DONE.
  - Default constants ADDR_W_DEF=8, KEY_BYTES_DEF=3.
  - Function key_byte(key, idx) returning byte idx, MSB-first.
- One optional sub-module, rc4_key_byte_sel: combinational mux selecting the kidx-th key byte from the latched key vector.
- FSM and datapath stay in rc4_ksa_engine.

Test Plan:
- Defaults, key 24'h000249, with the RAM model attached:
  - Writes 0..255 occur during INIT.
  - i=0: j=0; writes (addr0,data0) then (addr0,data0).
  - i=1: j=3; writes (addr1,data3) then (addr3,data1).
  - i=2: j=0x4E; writes (addr2,data0x4E) then (addr0x4E,data2).
  - done=1 exactly 1792 cycles after acceptance.
  - Final RAM matches the golden software KSA.
- ADDR_W=4, KEY_BYTES=1, key 8'h01:
  - First swap writes (addr0,data1) then (addr1,data0).
  - done at cycle 112.
  - Final RAM matches the golden model.
- Handshake:
  - Pulse start again mid-KSA and toggle secret_key to 24'hFFFFFF → no restart, result identical to the 24'h000249 run.
  - busy falls in the same cycle done rises.
- Reset mid-run: assert reset=0 during the KSA loop at i=100 → all outputs 0 immediately. Release and start → full 1792-cycle run with correct S.
- Back-to-back: in DONE, start with key 24'h123456 → done drops, INIT restarts at address 0, final RAM matches the golden model for the new key.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package rc4_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int KEY_BYTES_DEF  = 3;
  localparam int KEY_BYTES_MAX  = 32;
  localparam int KEY_W_MAX      = 8 * KEY_BYTES_MAX;

  // One state per RAM access phase of the engine.
  typedef enum logic [3:0] {
    IDLE = 4'd0,
    INIT = 4'd1,
    RD_I = 4'd2,
    WT_I = 4'd3,
    RD_J = 4'd4,
    WT_J = 4'd5,
    WR_I = 4'd6,
    WR_J = 4'd7,
    DONE = 4'd8
  } state_t;

  // Byte idx of a key that is left-aligned in a KEY_W_MAX-bit vector.
  // Byte 0 is the most significant byte of the key.
  function automatic logic [7:0] key_byte(input logic [KEY_W_MAX-1:0] key,
                                          input int unsigned        idx);
    return key[KEY_W_MAX-1 - 8*idx -: 8];
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Combinational selector returning the kidx-th byte (MSB-first) of the key.
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF,
  parameter int KIDX_W    = 2
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [KIDX_W-1:0]      kidx,
  output logic [7:0]             sel_byte
);

  // The table is padded to a power of two so kidx indexes it without
  // a range check; slots past the key length read as zero and are never
  // selected because kidx wraps at KEY_BYTES-1.
  localparam int SLOTS = 1 << KIDX_W;

  logic [KEY_W_MAX-1:0] key_left;
  logic [7:0]           slot [SLOTS];

  assign key_left = KEY_W_MAX'(key) << (8 * (KEY_BYTES_MAX - KEY_BYTES));

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < KEY_BYTES) begin : g_used
        assign slot[gi] = key_byte(key_left, gi);
      end else begin : g_pad
        assign slot[gi] = 8'h00;
      end
    end
  endgenerate

  assign sel_byte = slot[kidx];

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: fills an external single-port S-box RAM with
// the identity permutation, then runs the KSA swap loop against it.
// All RAM-facing outputs are registered and computed one cycle ahead.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [ADDR_W-1:0]      q,
  output logic [ADDR_W-1:0]      address,
  output logic [ADDR_W-1:0]      data,
  output logic                   wren,
  output logic                   busy,
  output logic                   done
);

  localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST    = {ADDR_W{1'b1}};
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

  state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]      i_reg, i_next;
  logic [ADDR_W-1:0]      j_reg, j_next;
  logic [KIDX_W-1:0]      kidx_reg, kidx_next;
  logic [ADDR_W-1:0]      si_reg, si_next;
  logic [8*KEY_BYTES-1:0] key_reg, key_next;
  logic [ADDR_W-1:0]      address_reg, address_next;
  logic [ADDR_W-1:0]      data_reg, data_next;
  logic                   wren_reg, wren_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;

  logic [7:0]             kbyte;
  logic [ADDR_W-1:0]      kbyte_w;
  logic [ADDR_W-1:0]      j_sum;

  rc4_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KIDX_W    (KIDX_W)
  ) u_key_sel (
    .key      (key_reg),
    .kidx     (kidx_reg),
    .sel_byte (kbyte)
  );

  // Narrow S-boxes use only the low bits of each key byte; the sum wraps mod N.
  assign kbyte_w = ADDR_W'(kbyte);
  assign j_sum   = j_reg + q + kbyte_w;

  // Next-state and next-output logic; outputs are set for the state being entered.
  always_comb begin
    state_next   = state_reg;
    i_next       = i_reg;
    j_next       = j_reg;
    kidx_next    = kidx_reg;
    si_next      = si_reg;
    key_next     = key_reg;
    address_next = address_reg;
    data_next    = data_reg;
    wren_next    = 1'b0;
    busy_next    = busy_reg;
    done_next    = done_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          key_next     = secret_key;
          i_next       = '0;
          j_next       = '0;
          kidx_next    = '0;
          busy_next    = 1'b1;
          done_next    = 1'b0;
          address_next = '0;
          data_next    = '0;
          wren_next    = 1'b1;
          state_next   = INIT;
        end
      end
      INIT: begin
        if (i_reg == I_LAST) begin
          i_next       = '0;
          address_next = '0;
          state_next   = RD_I;
        end else begin
          i_next       = i_reg + 1'b1;
          address_next = i_reg + 1'b1;
          data_next    = i_reg + 1'b1;
          wren_next    = 1'b1;
        end
      end
      RD_I: begin
        address_next = i_reg;
        state_next   = WT_I;
      end
      WT_I: begin
        si_next      = q;
        j_next       = j_sum;
        address_next = j_sum;
        state_next   = RD_J;
      end
      RD_J: begin
        state_next = WT_J;
      end
      WT_J: begin
        // S[j] goes straight into the write-data register for the S[i] write.
        address_next = i_reg;
        data_next    = q;
        wren_next    = 1'b1;
        state_next   = WR_I;
      end
      WR_I: begin
        address_next = j_reg;
        data_next    = si_reg;
        wren_next    = 1'b1;
        state_next   = WR_J;
      end
      WR_J: begin
        if (i_reg == I_LAST) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          i_next       = i_reg + 1'b1;
          kidx_next    = (kidx_reg == KIDX_LAST) ? '0 : kidx_reg + 1'b1;
          address_next = i_reg + 1'b1;
          state_next   = RD_I;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      i_reg       <= '0;
      j_reg       <= '0;
      kidx_reg    <= '0;
      si_reg      <= '0;
      key_reg     <= '0;
      address_reg <= '0;
      data_reg    <= '0;
      wren_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      i_reg       <= i_next;
      j_reg       <= j_next;
      kidx_reg    <= kidx_next;
      si_reg      <= si_next;
      key_reg     <= key_next;
      address_reg <= address_next;
      data_reg    <= data_next;
      wren_reg    <= wren_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign address = address_reg;
  assign data    = data_reg;
  assign wren    = wren_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule
